neat_child_gene_pipe: RTL
=========================

# neat_child_gene_pipe

Two-stage, valid/ready pipelined child-gene builder for the NEAT reproduction datapath. It sits directly downstream of the crossover/mutation select logic. It consumes one aligned parent-gene pair plus a 56-bit random word per cycle, picks the inherited parent, mutates each attribute under a probability threshold and streams out the child gene. It also keeps per-genome gene and mutation counts, which are reported on the genome's last gene.

## Interface
Parameters:
- GENE_SZ, 64, gene width. Layout: [63:48] key, [47:40] attr1, [39:32] attr2, [31:24] attr3, [23:0] payload.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  parent pair valid.
- in_ready  out  1  pipe can accept.
- gene1  in  GENE_SZ  parent 1 gene (fitter parent).
- gene2  in  GENE_SZ  parent 2 gene, same key.
- gene_type  in  1  0 = node, 1 = conn.
- bias  in  1  1 = gene2 absent (disjoint/excess); force gene1.
- in_last  in  1  last gene of the genome.
- rnd  in  56  random bytes. [7:0] crossover; [15:8]/[23:16]/[31:24] mutate decision attr1/2/3; [39:32]/[47:40]/[55:48] mutate value attr1/2/3.
- mutation_prob  in  8  threshold, Q1.7; sampled with each accepted pair.
- out_valid  out  1  child gene valid.
- out_ready  in  1  consumer accepts.
- out_gene  out  GENE_SZ  child gene.
- out_last  out  1  last gene of the genome.
- done  out  1  one-cycle pulse: genome statistics are valid.
- genome_genes  out  CNT_W  genes emitted in the finished genome.
- genome_muts  out  CNT_W  attributes mutated in the finished genome.

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage A (select), on accept:
  - Take gene2 iff bias==0 && rnd[7:0] > 8'h40. Otherwise take gene1.
  - Register the chosen gene, gene_type, in_last, rnd[55:8] and mutation_prob.
- Stage B (mutate), per attribute i:
  - Mutate iff decision_byte_i < mutation_prob (strict). mutation_prob=0 never mutates.
  - Replacement values:
    - Node: attr1 = value byte; attr2 = value & 8'h0F; attr3 = value & 8'h07.
    - Conn: attr1 = value & 8'h01; attr2 = 0; attr3 = 0.
  - Key and payload always pass through from the chosen parent.
  - The stage-B register holds the child gene and a 2-bit mutate count (0..3).
- Statistics, updated on each output transfer:
  - gene_cnt += 1; mut_cnt += mutate count. Both saturate at all-ones.
  - If out_last: genome_genes/genome_muts <= totals including this gene; live counters clear to 0; done pulses the next cycle.
  - genome_* hold until the next out_last transfer.

## Timing
- Latency: accept in cycle N -> out_valid in cycle N+2 with no stall. Throughput 1 gene/cycle.
- in_ready = !A_valid || !B_valid || out_ready. Stage A advances into B whenever B is empty or transferring.
- Backpressure: with out_ready=0, both stages fill and in_ready drops. out_gene/out_last remain stable while out_valid && !out_ready.
- in_valid with in_ready=0: inputs are ignored. The producer holds them.
- Reset (any cycle, including mid-genome):
  - Clears stage valids, out_gene, out_last, done, both live counters and genome_*.
  - In-flight genes are dropped.
  - in_ready is 0 while rst=1 and 1 the cycle after.
- Back-to-back genomes: an out_last transfer and the next genome's first transfer in consecutive cycles count separately. The first gene after last starts at gene_cnt=1.

## Structure
- Shared package neat_gene_pkg:
  - Field offsets KEY_LSB=48, ATTR1_LSB=40, ATTR2_LSB=32, ATTR3_LSB=24.
  - ATTR_SZ=8; HALF=8'h40.
  - Node masks 8'hFF/8'h0F/8'h07; conn masks 8'h01/8'h00/8'h00.
  - Gene-type encodings NODE=0, CONN=1.
- Sub-module gene_attr_mutate (one per attribute, three instances):
  - Inputs: attr, decision, value, prob, gene_type, lane index (parameter).
  - Outputs: new attr, mutated flag.

## Test plan
- Crossover: node pair, gene1 attrs 11/22/33, gene2 attrs 44/55/66, bias=0, rnd[7:0]=8'h41, prob=0 -> out_gene has attrs 44/55/66, latency 2.
- Same pair with rnd[7:0]=8'h40 -> gene1 attrs. Same pair with bias=1, rnd[7:0]=8'hFF -> gene1 attrs.
- Mutation masks, prob=8'h80:
  - Decisions 8'h10/8'h7F/8'h80, values 8'hAB/8'hAB/8'hAB, node -> attrs AB/0B/unchanged, mutate count 2.
  - Same stimulus as conn -> attrs 01/00/unchanged.
- Backpressure: 5 genes streamed, out_ready low for 4 cycles mid-stream -> in_ready drops after 2 buffered, no loss or duplication, order preserved, out_gene stable while stalled.
- Statistics: 3-gene genome with mutate counts 1/0/3, last on gene 3 -> done pulse one cycle after gene 3 transfers, genome_genes=3, genome_muts=4. Next genome starts from zero.
- Reset mid-stream: rst asserted with both stages full -> next cycle out_valid=0, done=0, counters 0; in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/neat_gene_pkg.sv
// rtl/neat_gene_pkg.sv - shared gene field layout, masks and type encodings
package neat_gene_pkg;

  localparam int KEY_LSB   = 48;
  localparam int ATTR1_LSB = 40;
  localparam int ATTR2_LSB = 32;
  localparam int ATTR3_LSB = 24;
  localparam int ATTR_SZ   = 8;

  // Crossover threshold: gene2 wins when the crossover byte is strictly above this
  localparam logic [ATTR_SZ-1:0] HALF = 8'h40;

  localparam logic [ATTR_SZ-1:0] NODE_MASK1 = 8'hFF;
  localparam logic [ATTR_SZ-1:0] NODE_MASK2 = 8'h0F;
  localparam logic [ATTR_SZ-1:0] NODE_MASK3 = 8'h07;
  localparam logic [ATTR_SZ-1:0] CONN_MASK1 = 8'h01;
  localparam logic [ATTR_SZ-1:0] CONN_MASK2 = 8'h00;
  localparam logic [ATTR_SZ-1:0] CONN_MASK3 = 8'h00;

  typedef enum logic {
    NODE = 1'b0,
    CONN = 1'b1
  } gene_type_e;

  // Replacement mask for attribute lane 0..2 given the gene type
  function automatic logic [ATTR_SZ-1:0] attr_mask(input int lane, input logic gtype);
    logic [ATTR_SZ-1:0] m;
    if (gtype == CONN) begin
      m = (lane == 0) ? CONN_MASK1 : (lane == 1) ? CONN_MASK2 : CONN_MASK3;
    end else begin
      m = (lane == 0) ? NODE_MASK1 : (lane == 1) ? NODE_MASK2 : NODE_MASK3;
    end
    return m;
  endfunction

  // Bit offset of attribute lane 0..2 inside a gene
  function automatic int attr_lsb(input int lane);
    return (lane == 0) ? ATTR1_LSB : (lane == 1) ? ATTR2_LSB : ATTR3_LSB;
  endfunction

endpackage

// File: rtl/gene_attr_mutate.sv
// rtl/gene_attr_mutate.sv - per-attribute probabilistic mutation lane
module gene_attr_mutate
  import neat_gene_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [ATTR_SZ-1:0] attr,
  input  logic [ATTR_SZ-1:0] decision,
  input  logic [ATTR_SZ-1:0] value,
  input  logic [ATTR_SZ-1:0] prob,
  input  logic               gene_type,
  output logic [ATTR_SZ-1:0] new_attr,
  output logic               mutated
);

  // Strict compare so a zero probability can never mutate
  always_comb begin
    mutated  = (decision < prob);
    new_attr = mutated ? (value & attr_mask(LANE, gene_type)) : attr;
  end

endmodule

// File: rtl/neat_child_gene_pipe.sv
// rtl/neat_child_gene_pipe.sv - two-stage child gene select/mutate pipe with genome stats
module neat_child_gene_pipe
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [GENE_SZ-1:0] gene1,
  input  logic [GENE_SZ-1:0] gene2,
  input  logic               gene_type,
  input  logic               bias,
  input  logic               in_last,
  input  logic [55:0]        rnd,
  input  logic [7:0]         mutation_prob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GENE_SZ-1:0] out_gene,
  output logic               out_last,
  output logic               done,
  output logic [CNT_W-1:0]   genome_genes,
  output logic [CNT_W-1:0]   genome_muts
);

  // Stage A (select) registers
  logic               a_valid;
  logic [GENE_SZ-1:0] a_gene;
  logic               a_type;
  logic               a_last;
  logic [47:0]        a_rnd;
  logic [7:0]         a_prob;

  // Stage B (mutate) registers
  logic               b_valid;
  logic [1:0]         b_mcnt;

  // Live per-genome counters
  logic [CNT_W-1:0]   gene_cnt;
  logic [CNT_W-1:0]   mut_cnt;

  logic               accept;
  logic               xfer;
  logic               b_adv;
  logic               take_gene2;

  logic [ATTR_SZ-1:0] attr_new [3];
  logic [2:0]         mut_flag;
  logic [GENE_SZ-1:0] child;
  logic [1:0]         child_mcnt;

  logic [CNT_W:0]     gene_sum;
  logic [CNT_W:0]     mut_sum;
  logic [CNT_W-1:0]   gene_next;
  logic [CNT_W-1:0]   mut_next;

  // Handshake: B frees up when empty or draining, A frees up when empty or moving into B
  always_comb begin
    b_adv      = !b_valid || out_ready;
    in_ready   = !rst && (!a_valid || b_adv);
    accept     = in_valid && in_ready;
    xfer       = b_valid && out_ready;
    take_gene2 = !bias && (rnd[7:0] > HALF);
    out_valid  = b_valid;
  end

  // Stage A: capture chosen parent and the randomness it will need in stage B
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_gene  <= '0;
      a_type  <= 1'b0;
      a_last  <= 1'b0;
      a_rnd   <= '0;
      a_prob  <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_gene  <= take_gene2 ? gene2 : gene1;
      a_type  <= gene_type;
      a_last  <= in_last;
      a_rnd   <= rnd[55:8];
      a_prob  <= mutation_prob;
    end else if (b_adv) begin
      a_valid <= 1'b0;
    end
  end

  // One mutation lane per attribute; decision bytes in a_rnd[23:0], value bytes in a_rnd[47:24]
  for (genvar i = 0; i < 3; i++) begin : g_lane
    gene_attr_mutate #(
      .LANE(i)
    ) u_mutate (
      .attr      (a_gene[attr_lsb(i) +: ATTR_SZ]),
      .decision  (a_rnd[8*i +: 8]),
      .value     (a_rnd[24 + 8*i +: 8]),
      .prob      (a_prob),
      .gene_type (a_type),
      .new_attr  (attr_new[i]),
      .mutated   (mut_flag[i])
    );
  end

  // Reassemble child: key and payload untouched, attributes from the lanes
  always_comb begin
    child      = {a_gene[GENE_SZ-1:KEY_LSB], attr_new[0], attr_new[1], attr_new[2],
                  a_gene[ATTR3_LSB-1:0]};
    child_mcnt = {1'b0, mut_flag[0]} + {1'b0, mut_flag[1]} + {1'b0, mut_flag[2]};
  end

  // Stage B: holds output steady while stalled, reloads from A when it can advance
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid  <= 1'b0;
      out_gene <= '0;
      out_last <= 1'b0;
      b_mcnt   <= '0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        out_gene <= child;
        out_last <= a_last;
        b_mcnt   <= child_mcnt;
      end
    end
  end

  // Saturating totals including the gene currently transferring
  always_comb begin
    gene_sum  = {1'b0, gene_cnt} + {{CNT_W{1'b0}}, 1'b1};
    mut_sum   = {1'b0, mut_cnt} + {{(CNT_W-1){1'b0}}, b_mcnt};
    gene_next = gene_sum[CNT_W] ? '1 : gene_sum[CNT_W-1:0];
    mut_next  = mut_sum[CNT_W]  ? '1 : mut_sum[CNT_W-1:0];
  end

  // Statistics: accumulate per transfer, publish and restart on the genome's last gene
  always_ff @(posedge clk) begin
    if (rst) begin
      gene_cnt     <= '0;
      mut_cnt      <= '0;
      genome_genes <= '0;
      genome_muts  <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        if (out_last) begin
          genome_genes <= gene_next;
          genome_muts  <= mut_next;
          gene_cnt     <= '0;
          mut_cnt      <= '0;
          done         <= 1'b1;
        end else begin
          gene_cnt <= gene_next;
          mut_cnt  <= mut_next;
        end
      end
    end
  end

endmodule
